// File: rtl/pbus_arbiter.sv
// Two-master round-robin arbiter in front of the peripheral bus switch master port.
// Registered grant, held until ack, address error, owner abandon or watchdog timeout.
module pbus_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TW      = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,

   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,

   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,

   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_adr_err_i,

   output logic [1:0]  grant_o
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2,
      ERR  = 2'd3
   } state_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
   } req_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          m0_err_q, m0_err_d;
   logic          m1_err_q, m1_err_d;

   logic          own;
   logic          own_stb;
   req_t          m0_req, m1_req, s_req;

   assign m0_req  = '{we: m0_we_i, adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i};
   assign m1_req  = '{we: m1_we_i, adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i};
   assign own     = (state_q == GNT1);
   assign own_stb = own ? m1_stb_i : m0_stb_i;

   // State, round-robin history, watchdog and error pulse registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         m0_err_q <= m0_err_d;
         m1_err_q <= m1_err_d;
      end
   end

   // Next-state: arbitration in IDLE, prioritised termination in GNTx
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      cnt_d    = '0;
      m0_err_d = 1'b0;
      m1_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (m0_stb_i && m1_stb_i) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (m0_stb_i) begin
               state_d = GNT0;
            end else if (m1_stb_i) begin
               state_d = GNT1;
            end
         end
         GNT0, GNT1: begin
            cnt_d = cnt_q + TW'(1);
            if (s_ack_i) begin
               state_d = IDLE;
               last_d  = own;
            end else if (s_adr_err_i && own_stb) begin
               state_d  = ERR;
               last_d   = own;
               m0_err_d = !own;
               m1_err_d = own;
            end else if (!own_stb) begin
               state_d = IDLE;
               last_d  = own;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = ERR;
               last_d   = own;
               m0_err_d = !own;
               m1_err_d = own;
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus steering: only the owner reaches the switch, and only while granted
   always_comb begin
      s_req    = '0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_dat_o = '0;
      unique case (state_q)
         GNT0: begin
            s_req    = m0_req;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i;
            m0_dat_o = s_dat_i;
         end
         GNT1: begin
            s_req    = m1_req;
            s_stb_o  = m1_stb_i;
            m1_ack_o = s_ack_i;
            m1_dat_o = s_dat_i;
         end
         default: begin
            s_req = '0;
         end
      endcase
   end

   assign s_we_o   = s_req.we;
   assign s_adr_o  = s_req.adr;
   assign s_dat_o  = s_req.dat;
   assign s_sel_o  = s_req.sel;
   assign m0_err_o = m0_err_q;
   assign m1_err_o = m1_err_q;
   assign grant_o  = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_pbus_arbiter.sv
// Directed bench for pbus_arbiter: arbitration, termination paths and async reset.
module tb_pbus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_stb, m0_we, m1_stb, m1_we;
   logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_rdat, m1_rdat;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_stb, s_we;
   logic [31:0] s_adr, s_wdat, s_rdat;
   logic [3:0]  s_sel;
   logic        s_ack, s_adr_err;
   logic [1:0]  grant;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pbus_arbiter #(.TIMEOUT(4), .TW(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
      .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
      .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
      .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_adr_err_i(s_adr_err),
      .grant_o(grant)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
      m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
      s_rdat = '0; s_ack = 0; s_adr_err = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant); end
      checks++; if (s_stb !== 1'b0) begin failures++; $display("FAIL reset_s_stb: got %b want 0", s_stb); end
      checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin failures++; $display("FAIL reset_ack_err: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
      checks++; if (s_adr !== 32'h0) begin failures++; $display("FAIL reset_s_adr: got %h want 0", s_adr); end
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      cyc();
      m0_stb = 1; m0_adr = 32'h1000_0000; m0_sel = 4'hF;
      m1_stb = 1; m1_we = 1; m1_adr = 32'h2000_0008; m1_wdat = 32'hCAFE_0001; m1_sel = 4'b0011;
      s_ack = 1;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rr_idle0: got %b want 00", grant); end
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         cyc();
         @(negedge clk);
         checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp_g); end
         checks++; if ({m1_ack, m0_ack} !== exp_g) begin failures++; $display("FAIL rr_ack%0d: got %b want %b", i, {m1_ack, m0_ack}, exp_g); end
         if (i % 2 == 1) begin
            checks++; if ({s_we, s_wdat, s_sel} !== {1'b1, 32'hCAFE_0001, 4'b0011}) begin failures++; $display("FAIL rr_m1_write%0d: got we=%b dat=%h sel=%b want we=1 dat=cafe0001 sel=0011", i, s_we, s_wdat, s_sel); end
         end
         cyc();
         if (i == 3) clear_inputs();
         @(negedge clk);
         checks++; if ({grant, m1_ack, m0_ack} !== 4'b0000) begin failures++; $display("FAIL rr_gap%0d: got grant=%b acks=%b want 00/00", i, grant, {m1_ack, m0_ack}); end
      end
   endtask

   task automatic test_single_read();
      cyc();
      m0_stb = 1; m0_we = 0; m0_adr = 32'h1000_0004; m0_sel = 4'hF;
      @(negedge clk);
      checks++; if (s_stb !== 1'b0) begin failures++; $display("FAIL rd_stb_req_cycle: got %b want 0", s_stb); end
      cyc();
      @(negedge clk);
      checks++; if ({s_stb, grant} !== 3'b101) begin failures++; $display("FAIL rd_gnt1: got stb=%b grant=%b want 1/01", s_stb, grant); end
      checks++; if (s_adr !== 32'h1000_0004) begin failures++; $display("FAIL rd_s_adr: got %h want 10000004", s_adr); end
      checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL rd_early_ack: got %b want 0", m0_ack); end
      cyc();
      cyc();
      s_ack = 1; s_rdat = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL rd_ack: got %b want 1", m0_ack); end
      checks++; if (m0_rdat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %h want deadbeef", m0_rdat); end
      checks++; if ({m1_ack, m1_rdat, m0_err} !== 34'h0) begin failures++; $display("FAIL rd_non_owner: got ack=%b dat=%h err=%b want 0", m1_ack, m1_rdat, m0_err); end
      cyc();
      clear_inputs();
      @(negedge clk);
      checks++; if ({grant, s_stb, m0_ack} !== 4'b0000) begin failures++; $display("FAIL rd_back_idle: got grant=%b stb=%b ack=%b want 0", grant, s_stb, m0_ack); end
   endtask

   task automatic test_timeout();
      int stb_cycles = 0;
      cyc();
      m0_stb = 1; m0_adr = 32'h1000_00A0; m0_sel = 4'hF;
      m1_stb = 1; m1_adr = 32'h2000_0010; m1_sel = 4'hF;
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         @(negedge clk);
         if (s_stb === 1'b1) stb_cycles++;
         checks++; if ({grant, m1_err} !== 3'b100) begin failures++; $display("FAIL to_gnt%0d: got grant=%b err=%b want 10/0", k, grant, m1_err); end
      end
      checks++; if (s_adr !== 32'h2000_0010) begin failures++; $display("FAIL to_s_adr: got %h want 20000010", s_adr); end
      cyc();
      @(negedge clk);
      checks++; if (stb_cycles !== 4) begin failures++; $display("FAIL to_stb_cycles: got %0d want 4", stb_cycles); end
      checks++; if ({s_stb, grant, m1_err, m0_err, m1_ack} !== 6'b000100) begin failures++; $display("FAIL to_err: got stb=%b grant=%b m1_err=%b m0_err=%b m1_ack=%b want 0/00/1/0/0", s_stb, grant, m1_err, m0_err, m1_ack); end
      cyc();
      m1_stb = 0;
      @(negedge clk);
      checks++; if ({grant, m1_err, s_stb} !== 4'b0000) begin failures++; $display("FAIL to_idle: got grant=%b err=%b stb=%b want 0", grant, m1_err, s_stb); end
      cyc();
      s_ack = 1;
      @(negedge clk);
      checks++; if ({grant, m0_ack} !== 3'b011) begin failures++; $display("FAIL to_pending_m0: got grant=%b ack=%b want 01/1", grant, m0_ack); end
      checks++; if (s_adr !== 32'h1000_00A0) begin failures++; $display("FAIL to_m0_adr: got %h want 100000a0", s_adr); end
      cyc();
      clear_inputs();
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL to_end_idle: got %b want 00", grant); end
   endtask

   task automatic test_adr_err();
      cyc();
      m0_stb = 1; m0_adr = 32'hF000_0000; m0_sel = 4'hF;
      cyc();
      s_adr_err = 1;
      @(negedge clk);
      checks++; if ({grant, m0_ack, m0_err} !== 4'b0100) begin failures++; $display("FAIL ae_gnt: got grant=%b ack=%b err=%b want 01/0/0", grant, m0_ack, m0_err); end
      cyc();
      s_adr_err = 0;
      @(negedge clk);
      checks++; if ({m0_err, m0_ack, s_stb, m1_err} !== 4'b1000) begin failures++; $display("FAIL ae_err_pulse: got err=%b ack=%b stb=%b m1_err=%b want 1/0/0/0", m0_err, m0_ack, s_stb, m1_err); end
      cyc();
      m0_stb = 0;
      @(negedge clk);
      checks++; if ({m0_err, grant} !== 3'b000) begin failures++; $display("FAIL ae_err_once: got err=%b grant=%b want 0/00", m0_err, grant); end
      cyc();
      m0_stb = 1;
      cyc();
      s_ack = 1; s_adr_err = 1;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL ae_ack_wins_ack: got %b want 1", m0_ack); end
      cyc();
      clear_inputs();
      @(negedge clk);
      checks++; if ({m0_err, grant} !== 3'b000) begin failures++; $display("FAIL ae_ack_wins_noerr: got err=%b grant=%b want 0/00", m0_err, grant); end
   endtask

   task automatic test_abandon_and_ack_vs_timeout();
      cyc();
      m0_stb = 1; m0_adr = 32'h1000_0100; m0_sel = 4'hF;
      cyc();
      m1_stb = 1; m1_adr = 32'h2000_0200; m1_sel = 4'hF;
      @(negedge clk);
      checks++; if ({grant, m1_ack} !== 3'b010) begin failures++; $display("FAIL ab_m1_held: got grant=%b m1_ack=%b want 01/0", grant, m1_ack); end
      cyc();
      m0_stb = 0;
      @(negedge clk);
      checks++; if ({grant, s_stb} !== 3'b010) begin failures++; $display("FAIL ab_drop: got grant=%b stb=%b want 01/0", grant, s_stb); end
      cyc();
      @(negedge clk);
      checks++; if ({grant, m0_ack, m0_err} !== 4'b0000) begin failures++; $display("FAIL ab_idle: got grant=%b ack=%b err=%b want 0", grant, m0_ack, m0_err); end
      cyc();
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL ab_m1_granted: got %b want 10", grant); end
      cyc();
      cyc();
      cyc();
      s_ack = 1;
      @(negedge clk);
      checks++; if ({grant, m1_ack, m1_err} !== 4'b1010) begin failures++; $display("FAIL ab_ack_at_limit: got grant=%b ack=%b err=%b want 10/1/0", grant, m1_ack, m1_err); end
      cyc();
      clear_inputs();
      @(negedge clk);
      checks++; if ({m1_err, grant} !== 3'b000) begin failures++; $display("FAIL ab_no_err_after_ack: got err=%b grant=%b want 0/00", m1_err, grant); end
   endtask

   task automatic test_reset_mid_transfer();
      cyc();
      m0_stb = 1; m0_adr = 32'h1000_0000;
      cyc();
      m0_stb = 0;
      cyc();
      m1_stb = 1; m1_adr = 32'h2000_0300; m1_sel = 4'hF;
      cyc();
      s_ack = 1;
      @(negedge clk);
      checks++; if ({grant, m1_ack, s_stb} !== 4'b1011) begin failures++; $display("FAIL rst_pre: got grant=%b ack=%b stb=%b want 10/1/1", grant, m1_ack, s_stb); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({s_stb, grant, m1_ack, m1_err} !== 5'b00000) begin failures++; $display("FAIL rst_async_ctl: got stb=%b grant=%b ack=%b err=%b want 0", s_stb, grant, m1_ack, m1_err); end
      checks++; if (s_adr !== 32'h0) begin failures++; $display("FAIL rst_async_adr: got %h want 0", s_adr); end
      cyc();
      s_ack = 0; m0_stb = 1; m1_stb = 1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_idle: got %b want 00", grant); end
      cyc();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rst_tie_m0_first: got %b want 01", grant); end
      cyc();
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_read();
      test_timeout();
      test_adr_err();
      test_abandon_and_ack_vs_timeout();
      test_reset_mid_transfer();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pbus_arbiter.md
# pbus_arbiter

Two-master arbiter for the peripheral bus: it shares the single master port of the peripheral bus switch between the CPU data port (m0) and a second requester such as DMA or debug (m1). Round-robin arbitration on a registered grant. The grant is held until the selected slave acks, the switch flags an address error, the owner abandons the cycle, or a watchdog timeout expires. Errors are reported back to the owning master as a one-cycle error pulse. The block sits between the masters and the switch's `master_*` ports; the switch's `adr_err_o` feeds `s_adr_err_i`.

## Interface
- `TIMEOUT`, default 255: cycles a granted transfer may wait for ack before it is aborted; legal range 2..2^TW-1.
- `TW`, default 8: width of the watchdog counter.

Ports (format: name, direction, width, meaning):
- `clk_i`, in, 1: single clock; all state on the rising edge.
- `rst_n_i`, in, 1: asynchronous, active-low reset.
- `m0_stb_i`, `m0_we_i`, in, 1 each: master 0 strobe and write enable.
- `m0_adr_i`, `m0_dat_i`, in, 32 each: master 0 address and write data.
- `m0_sel_i`, in, 4: master 0 byte selects.
- `m0_dat_o`, out, 32: read data to master 0.
- `m0_ack_o`, `m0_err_o`, out, 1 each: master 0 ack and error.
- `m1_*`: same set for master 1.
- `s_stb_o`, `s_we_o`, out, 1 each: to switch `master_stb_i` / `master_we_i`.
- `s_adr_o`, `s_dat_o`, out, 32 each: to switch `master_adr_i` / `master_dat_i`.
- `s_sel_o`, out, 4: to switch `master_sel_i`.
- `s_dat_i`, in, 32; `s_ack_i`, in, 1: from switch `master_dat_o` / `master_ack_o`.
- `s_adr_err_i`, in, 1: from switch `adr_err_o`.
- `grant_o`, out, 2: one-hot current owner; 00 when idle.

## Operation
State machine states: IDLE, GNT0, GNT1, ERR. Registered `last` holds the owner bit of the most recent completed grant. Registered `cnt` is TW bits wide.

**Reset**
- state = IDLE, `last` = 1 (so m0 wins the first tie), `cnt` = 0.
- Every output is 0.

**IDLE**
- Only m0 requesting: go to GNT0. Only m1 requesting: go to GNT1.
- Both requesting: grant the master that is not `last`.
- `s_stb_o` = 0; `cnt` cleared.

**GNTx**
- `s_we/adr/dat/sel_o` are driven combinationally from master x; `s_stb_o` = `mx_stb_i`.
- `mx_ack_o` = `s_ack_i`; `mx_dat_o` = `s_dat_i`.
- The non-owner sees ack = 0, err = 0, dat = 0. It is held with no timeout applied to it.
- `cnt` increments every GNT cycle.

**GNTx exits**, in priority order:
1. `s_ack_i`: go to IDLE, `last` = x. Ack wins over a same-cycle timeout or `s_adr_err_i`.
2. `s_adr_err_i` with `mx_stb_i`: go to ERR.
3. `mx_stb_i` = 0 (owner abandoned the cycle): go to IDLE, `last` = x, no err.
4. `cnt` == TIMEOUT-1: go to ERR.

**ERR**
- `s_stb_o` = 0.
- `mx_err_o` = 1 for exactly this cycle; this is a registered pulse to the previous owner.
- Next state IDLE, `last` = x.

**Outside GNTx**: all `s_*` outputs are 0 except in GNTx, so the switch never sees a stray strobe.

## Timing
- Arbitration latency: `s_stb_o` rises 1 cycle after a request is sampled in IDLE.
- Ack path (`s_ack_i` to `mx_ack_o`, `s_dat_i` to `mx_dat_o`) is combinational; zero added latency.
- After ack there is 1 mandatory IDLE cycle. Back-to-back transfers from a master holding `stb` are spaced ack, IDLE, GNT, i.e. a minimum of 2 cycles per transfer with a 0-wait slave.
- Masters must treat `ack` or `err` as cycle termination. Keeping `stb` high after either starts a new request.
- Timeout: with no ack, err pulses in cycle TIMEOUT+1 after the GNT state is entered (GNT cycles 1..TIMEOUT, then ERR).
- Reset mid-transfer: all outputs go to 0 immediately and asynchronously, with no ack or err. `last` returns to 1.
- `grant_o` equals the registered state decode: 01 in GNT0, 10 in GNT1, 00 otherwise (including ERR).

## Test plan
- **Single read:** m0 read of 0x1000_0004; slave acks in the 3rd GNT cycle with 0xDEADBEEF. Required: `s_stb_o` rises 1 cycle after `m0_stb_i`; `m0_ack_o` is coincident with `s_ack_i`; `m0_dat_o` = 0xDEADBEEF; `m1_ack_o` stays 0; state returns to IDLE.
- **Tie round-robin:** m0 and m1 both hold stb; slave always acks in the 1st GNT cycle. Required grant order 0,1,0,1. Each `mx_ack_o` pulses once per 2-cycle window, and a write by m1 presents `m1_dat_i` and `m1_sel_i` = 4'b0011 on `s_dat_o` / `s_sel_o`.
- **Timeout:** TIMEOUT = 4; m1 strobes and no ack arrives. Required: `s_stb_o` is high for exactly 4 cycles, then `m1_err_o` = 1 for one cycle with `s_stb_o` = 0, then IDLE. A pending m0 request is granted next.
- **Address error:** m0 strobes; `s_adr_err_i` = 1 in GNT0. Required: `m0_err_o` pulses on the next cycle and `m0_ack_o` stays 0. Repeat with `s_ack_i` and `s_adr_err_i` both high in the same cycle: ack only, no err.
- **Abandon and ack-vs-timeout:** m0 drops stb in its 2nd GNT cycle. Required: IDLE next cycle, no ack or err, and m1 (waiting) is granted. Then, with TIMEOUT = 4, an ack in the 4th GNT cycle gives ack and no err.
- **Reset mid-transfer:** assert `rst_n_i` low in GNT1 between clock edges. Required: `s_stb_o`, `grant_o`, `m1_ack_o`, `m1_err_o` and `s_adr_o` go to 0 immediately. After release, a tie is granted to m0 first.
